// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and the core's memory port.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES  = 8;
  localparam int OFFSET_BITS = 3;

  // Opcode encoding carried on req_we
  localparam logic OP_LD = 1'b0;
  localparam logic OP_SD = 1'b1;

  typedef struct packed {
    logic we;
    logic err;
    logic ld_ok;
  } dmem_rsp_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core (master) and the responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              resp_we;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_we
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read; contents are never reset.
module dmem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read register only loads on an access so the response word holds under back-pressure
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Stallable data-memory responder: one load/store in flight, fixed access latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic           clock,
  input  logic           reset_n,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_e            r_state;
  logic [1:0]        r_rst_sync;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  dmem_rsp_t         r_rsp;

  logic              w_access;
  logic              w_err;
  logic              w_wr;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  // Reset asserts immediately, but req_ready only rises once deassertion is synchronised
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_access = (r_state == WAIT) && (r_cnt == '0);
  assign w_err    = (r_addr[OFFSET_BITS-1:0] != '0) ||
                    ((r_addr >> OFFSET_BITS) >= ADDR_W'(DEPTH));
  assign w_wr     = w_access && (r_we == OP_SD) && !w_err;
  assign w_idx    = r_addr[OFFSET_BITS +: IDX_W];

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock   (clock),
    .i_we    (w_wr),
    .i_re    (w_access),
    .i_idx   (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rsp        <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_req_ready <= r_rst_sync[1];
          if (r_req_ready && bus.req_valid) begin
            r_we        <= bus.req_we;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_cnt       <= CNT_W'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp.we     <= r_we;
            r_rsp.err    <= w_err;
            r_rsp.ld_ok  <= (r_we == OP_LD) && !w_err;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rsp        <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_rsp.err;
  assign bus.resp_we    = r_rsp.we;
  assign bus.resp_rdata = r_rsp.ld_ok ? w_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized checks of two responders (LATENCY 2 and 1) against a word-array model.
module tb_dmem_responder;

  localparam int DEP = 1024;
  localparam int LAT [2] = '{2, 1};

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        tv [2];
  logic        twe [2];
  logic [63:0] taddr [2];
  logic [63:0] twd [2];
  logic        trr [2];
  logic        ordy [2];
  logic        ovld [2];
  logic        oerr [2];
  logic        owe [2];
  logic [63:0] ordata [2];

  dmem_responder_if #(.ADDR_W(64), .DATA_W(64)) b0 ();
  dmem_responder_if #(.ADDR_W(64), .DATA_W(64)) b1 ();

  dmem_responder #(.DEPTH(DEP), .LATENCY(2), .ADDR_W(64), .DATA_W(64)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(b0));
  dmem_responder #(.DEPTH(DEP), .LATENCY(1), .ADDR_W(64), .DATA_W(64)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(b1));

  assign b0.req_valid = tv[0];  assign b1.req_valid = tv[1];
  assign b0.req_we = twe[0];    assign b1.req_we = twe[1];
  assign b0.req_addr = taddr[0]; assign b1.req_addr = taddr[1];
  assign b0.req_wdata = twd[0]; assign b1.req_wdata = twd[1];
  assign b0.resp_ready = trr[0]; assign b1.resp_ready = trr[1];
  assign ordy[0] = b0.req_ready;    assign ordy[1] = b1.req_ready;
  assign ovld[0] = b0.resp_valid;   assign ovld[1] = b1.resp_valid;
  assign oerr[0] = b0.resp_err;     assign oerr[1] = b1.resp_err;
  assign owe[0] = b0.resp_we;       assign owe[1] = b1.resp_we;
  assign ordata[0] = b0.resp_rdata; assign ordata[1] = b1.resp_rdata;

  int total = 0;
  int bad = 0;
  int cycn = 0;
  int t_acc [2];
  logic [63:0] mdl [2][16];

  task automatic cyc();
    @(posedge clock);
    #1;
    cycn++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: wait ready, present, measure latency, check response, optional stall, accept.
  task automatic txn(input int d, input logic we, input logic [63:0] addr,
                     input logic [63:0] wd, input int hold, input string tag);
    int n;
    logic e;
    logic [63:0] er;
    int idx;
    n = 0;
    while (!ordy[d] && n < 20) begin cyc(); n++; end
    chk({tag, "-ready"}, 64'(ordy[d]), 64'd1);
    tv[d] = 1'b1; twe[d] = we; taddr[d] = addr; twd[d] = wd;
    cyc();
    t_acc[d] = cycn;
    tv[d] = 1'b0;
    e   = (addr[2:0] != 3'd0) || ((addr >> 3) >= 64'(DEP));
    idx = int'(addr[6:3]);
    er  = (we || e) ? 64'd0 : mdl[d][idx];
    if (we && !e) mdl[d][idx] = wd;
    n = 0;
    while (!ovld[d] && n < 40) begin cyc(); n++; end
    chk({tag, "-latency"}, 64'(n), 64'(LAT[d]));
    chk({tag, "-rdata"}, ordata[d], er);
    chk({tag, "-err"}, 64'(oerr[d]), 64'(e));
    chk({tag, "-we"}, 64'(owe[d]), 64'(we));
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk({tag, "-stall-valid"}, 64'(ovld[d]), 64'd1);
      chk({tag, "-stall-rdata"}, ordata[d], er);
      chk({tag, "-stall-err"}, 64'(oerr[d]), 64'(e));
      chk({tag, "-stall-ready"}, 64'(ordy[d]), 64'd0);
    end
    trr[d] = 1'b1;
    cyc();
    trr[d] = 1'b0;
    chk({tag, "-valid-drop"}, 64'(ovld[d]), 64'd0);
    chk({tag, "-ready-back"}, 64'(ordy[d]), 64'd1);
  endtask

  initial begin
    int d, r, prev;
    logic [63:0] a;
    for (int i = 0; i < 2; i++) begin
      tv[i] = 1'b0; twe[i] = 1'b0; taddr[i] = '0; twd[i] = '0; trr[i] = 1'b0; t_acc[i] = 0;
    end
    cyc(); cyc();
    for (int i = 0; i < 2; i++) begin
      chk("rst-ready", 64'(ordy[i]), 64'd0);
      chk("rst-valid", 64'(ovld[i]), 64'd0);
      chk("rst-err", 64'(oerr[i]), 64'd0);
      chk("rst-we", 64'(owe[i]), 64'd0);
      chk("rst-rdata", ordata[i], 64'd0);
    end
    reset_n = 1'b1;

    // Give every pooled word a known value in both models
    for (int i = 0; i < 16; i++) begin
      txn(0, 1'b1, 64'(i) << 3, {$urandom, $urandom}, 0, "pre0");
      txn(1, 1'b1, 64'(i) << 3, {$urandom, $urandom}, 0, "pre1");
    end

    txn(0, 1'b1, 64'h10, 64'hDEAD_BEEF_0000_0001, 0, "st10");
    txn(0, 1'b0, 64'h10, 64'h0, 0, "ld10");
    txn(0, 1'b0, 64'h0C, 64'h0, 0, "ld-mis");
    txn(0, 1'b1, 64'h0C, 64'h1234, 0, "st-mis");
    txn(0, 1'b0, 64'h08, 64'h0, 0, "ld08");
    txn(0, 1'b0, 64'h2000, 64'h0, 0, "ld-oor");
    txn(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, "ld-top");
    txn(0, 1'b0, 64'h18, 64'h0, 5, "ld-stall");

    // Reset while a store to 0x18 sits in the latency wait
    r = 0;
    while (!ordy[0] && r < 20) begin cyc(); r++; end
    chk("rw-ready", 64'(ordy[0]), 64'd1);
    tv[0] = 1'b1; twe[0] = 1'b1; taddr[0] = 64'h18; twd[0] = 64'h55;
    cyc();
    tv[0] = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rw-ready0", 64'(ordy[0]), 64'd0);
    chk("rw-valid0", 64'(ovld[0]), 64'd0);
    chk("rw-err0", 64'(oerr[0]), 64'd0);
    chk("rw-we0", 64'(owe[0]), 64'd0);
    chk("rw-rdata0", ordata[0], 64'd0);
    cyc(); cyc();
    reset_n = 1'b1;
    txn(0, 1'b0, 64'h18, 64'h0, 0, "ld18-after-rst");

    // Back-to-back loads at LATENCY=1: acceptances spaced LATENCY+2 apart
    txn(1, 1'b0, 64'h00, 64'h0, 0, "b2b");
    for (int i = 1; i < 5; i++) begin
      prev = t_acc[1];
      txn(1, 1'b0, 64'(i * 3) << 3, 64'h0, 0, "b2b");
      chk("b2b-spacing", 64'(t_acc[1] - prev), 64'(LAT[1] + 2));
    end

    for (int k = 0; k < 40; k++) begin
      d = k % 2;
      r = int'($urandom_range(0, 9));
      if (r < 7)      a = 64'($urandom_range(0, 15)) << 3;
      else if (r < 8) a = (64'($urandom_range(0, 15)) << 3) | 64'($urandom_range(1, 7));
      else            a = 64'(DEP * 8) + (64'($urandom_range(0, 1000)) << 3);
      txn(d, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
          int'($urandom_range(0, 3)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
